// File: rtl/rpm_pkg.sv
// Shared types and width helpers for the multi-channel RPM estimator.
// Every file of the estimator imports this package.
package rpm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } rpm_state_e;

    localparam int DEF_SCALE_MUL   = 5;
    localparam int DEF_SCALE_SHIFT = 4;

    function automatic int sum_width(input int count_w, input int avg_log2);
        return count_w + avg_log2;
    endfunction

    // 8 spare bits cover any 8-bit unsigned scale multiplier
    function automatic int prod_width(input int sum_w);
        return sum_w + 8;
    endfunction

    function automatic longint rpm_max(input int rpm_w);
        return (longint'(1) <<< (rpm_w - 1)) - 1;
    endfunction

    function automatic longint rpm_min(input int rpm_w);
        return -(longint'(1) <<< (rpm_w - 1));
    endfunction

endpackage

// File: rtl/rpm_scale_sat.sv
// Combinational multiply, shift toward zero and clamp into the RPM output range.
// One instance is shared by all channels of the estimator.
module rpm_scale_sat
    import rpm_pkg::*;
#(
    parameter int SUM_W       = 35,
    parameter int RPM_W       = 16,
    parameter int SCALE_MUL   = DEF_SCALE_MUL,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic signed [SUM_W-1:0] avg_i,
    output logic signed [RPM_W-1:0] rpm_o,
    output logic                    sat_o
);

    localparam int PROD_W = prod_width(SUM_W);
    localparam logic signed [PROD_W-1:0] MUL_C  = PROD_W'(SCALE_MUL);
    localparam logic signed [PROD_W-1:0] BIAS_C = PROD_W'((longint'(1) <<< SCALE_SHIFT) - 1);
    localparam logic signed [PROD_W-1:0] ZERO_C = '0;
    localparam logic signed [PROD_W-1:0] MAX_C  = PROD_W'(rpm_max(RPM_W));
    localparam logic signed [PROD_W-1:0] MIN_C  = PROD_W'(rpm_min(RPM_W));

    logic signed [PROD_W-1:0] avg_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] bias;
    logic signed [PROD_W-1:0] biased;
    logic signed [PROD_W-1:0] scaled;

    always_comb begin
        avg_ext = PROD_W'(avg_i);
        prod    = avg_ext * MUL_C;
        // adding 2^S-1 before the arithmetic shift turns floor into truncation for negatives
        bias    = prod[PROD_W-1] ? BIAS_C : ZERO_C;
        biased  = prod + bias;
        scaled  = biased >>> SCALE_SHIFT;

        if (scaled > MAX_C) begin
            rpm_o = MAX_C[RPM_W-1:0];
            sat_o = 1'b1;
        end else if (scaled < MIN_C) begin
            rpm_o = MIN_C[RPM_W-1:0];
            sat_o = 1'b1;
        end else begin
            rpm_o = scaled[RPM_W-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/rpm_multi_estimator.sv
// Multi-channel RPM estimator: coherent snapshot on a sample tick, wrap-safe delta,
// moving average and scale/saturate, one channel per cycle through a shared scaler.
module rpm_multi_estimator
    import rpm_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int COUNT_W     = 33,
    parameter int RPM_W       = 16,
    parameter int SAMPLE_DIV  = 250000,
    parameter int AVG_LOG2    = 2,
    parameter int SCALE_MUL   = DEF_SCALE_MUL,
    parameter int SCALE_SHIFT = DEF_SCALE_SHIFT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        clear,
    input  logic [CHANNELS*COUNT_W-1:0] count,
    output logic [CHANNELS*RPM_W-1:0]   rpm_out,
    output logic [CHANNELS-1:0]         rpm_sat,
    output logic                        rpm_valid
);

    localparam int SUM_W = sum_width(COUNT_W, AVG_LOG2);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [PTR_W-1:0]        PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic signed [SUM_W-1:0] AVG_BIAS = SUM_W'(DEPTH - 1);
    localparam logic signed [SUM_W-1:0] SUM_ZERO = '0;

    rpm_state_e                state_q;
    logic [DIV_W-1:0]          div_q;
    logic [CH_W-1:0]           ch_q;
    logic                      all_primed_q;
    logic [CHANNELS-1:0]       primed_q;
    logic [COUNT_W-1:0]        snap_q [CHANNELS];
    logic [COUNT_W-1:0]        last_q [CHANNELS];
    logic signed [COUNT_W-1:0] ring_q [CHANNELS][DEPTH];
    logic [PTR_W-1:0]          ptr_q  [CHANNELS];
    logic signed [SUM_W-1:0]   sum_q  [CHANNELS];
    logic signed [RPM_W-1:0]   rpm_q  [CHANNELS];
    logic [CHANNELS-1:0]       sat_q;
    logic                      valid_q;

    logic [COUNT_W-1:0]        count_ch [CHANNELS];
    logic                      tick;
    logic signed [COUNT_W-1:0] delta_d;
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [SUM_W-1:0]   bias_d;
    logic signed [SUM_W-1:0]   biased_d;
    logic signed [SUM_W-1:0]   avg_d;
    logic [PTR_W-1:0]          ptr_d;
    logic signed [RPM_W-1:0]   rpm_d;
    logic                      sat_d;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign count_ch[gi]                 = count[gi*COUNT_W +: COUNT_W];
            assign rpm_out[gi*RPM_W +: RPM_W]   = rpm_q[gi];
        end
    endgenerate

    assign rpm_sat   = sat_q;
    assign rpm_valid = valid_q;
    assign tick      = enable && (div_q == DIV_LAST);

    // Datapath for the channel selected by ch_q; modular subtraction makes counter wrap harmless
    always_comb begin
        delta_d  = snap_q[ch_q] - last_q[ch_q];
        sum_d    = sum_q[ch_q] + SUM_W'(delta_d) - SUM_W'(ring_q[ch_q][ptr_q[ch_q]]);
        bias_d   = sum_d[SUM_W-1] ? AVG_BIAS : SUM_ZERO;
        biased_d = sum_d + bias_d;
        avg_d    = biased_d >>> AVG_LOG2;
        ptr_d    = (ptr_q[ch_q] == PTR_LAST) ? '0 : ptr_q[ch_q] + 1'b1;
    end

    rpm_scale_sat #(
        .SUM_W       (SUM_W),
        .RPM_W       (RPM_W),
        .SCALE_MUL   (SCALE_MUL),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_scale (
        .avg_i (avg_d),
        .rpm_o (rpm_d),
        .sat_o (sat_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            div_q        <= '0;
            ch_q         <= '0;
            all_primed_q <= 1'b0;
            primed_q     <= '0;
            sat_q        <= '0;
            valid_q      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                snap_q[i] <= '0;
                last_q[i] <= '0;
                ptr_q[i]  <= '0;
                sum_q[i]  <= '0;
                rpm_q[i]  <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    ring_q[i][j] <= '0;
                end
            end
        end else if (clear) begin
            state_q      <= IDLE;
            div_q        <= '0;
            ch_q         <= '0;
            all_primed_q <= 1'b0;
            primed_q     <= '0;
            sat_q        <= '0;
            valid_q      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                ptr_q[i] <= '0;
                sum_q[i] <= '0;
                rpm_q[i] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    ring_q[i][j] <= '0;
                end
            end
        end else begin
            valid_q <= 1'b0;
            if (enable) begin
                div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (tick) begin
                        snap_q       <= count_ch;
                        all_primed_q <= &primed_q;
                        ch_q         <= '0;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    if (primed_q[ch_q]) begin
                        ring_q[ch_q][ptr_q[ch_q]] <= delta_d;
                        ptr_q[ch_q]               <= ptr_d;
                        sum_q[ch_q]               <= sum_d;
                        rpm_q[ch_q]               <= rpm_d;
                        sat_q[ch_q]               <= sat_d;
                    end else begin
                        primed_q[ch_q] <= 1'b1;
                    end
                    last_q[ch_q] <= snap_q[ch_q];
                    if (ch_q == CH_LAST) begin
                        state_q <= DONE;
                        valid_q <= all_primed_q;
                    end else begin
                        ch_q <= ch_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
